// File: rtl/a2d_chnl_scan.sv
// a2d_chnl_scan: periodic channel scanner/averager in front of the A2D SPI block.
// Each scan converts channels 0..NUM_CH-1 in order. Every channel takes
// 2**AVG_LOG2 samples, and one floor-averaged 12-bit result is published per channel.
module a2d_chnl_scan #(
  parameter int NUM_CH   = 4,
  parameter int AVG_LOG2 = 2,
  parameter int PERIOD   = 20000,
  parameter int TMO_CYC  = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic        ch_vld,
  output logic [2:0]  ch_id,
  output logic [11:0] ch_avg,
  output logic        scan_done,
  output logic        tmo_err
);

  localparam int ACC_W = 12 + AVG_LOG2;
  localparam int PER_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam int SMP_W = AVG_LOG2 + 1;
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << AVG_LOG2) - 1);
  localparam logic [2:0]       CH_LAST  = 3'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, PUB} state_t;

  // Floor average: the accumulator can never exceed 0xFFF * 2**AVG_LOG2,
  // so dropping the low AVG_LOG2 bits always fits in 12 bits.
  function automatic logic [11:0] avg_floor(input logic [ACC_W-1:0] sum);
    avg_floor = 12'(sum >> AVG_LOG2);
  endfunction

  state_t             state_q, state_d;
  logic [PER_W-1:0]   per_cnt_q, per_cnt_d;
  logic               pend_q, pend_d;
  logic [SMP_W-1:0]   smp_cnt_q, smp_cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [2:0]         cur_ch_q, cur_ch_d;
  logic               ch_vld_q, ch_vld_d;
  logic [2:0]         ch_id_q, ch_id_d;
  logic [11:0]        ch_avg_q, ch_avg_d;
  logic               scan_done_q, scan_done_d;
  logic               tmo_err_q, tmo_err_d;
  logic               tick;
  logic               last_ch;
  logic [ACC_W-1:0]   acc_sum;

  assign last_ch = (cur_ch_q == CH_LAST);
  assign acc_sum = acc_q + ACC_W'(res);

  // Scan-period timer: free-runs while enabled, parked at 0 otherwise.
  always_comb begin
    tick      = en && (per_cnt_q == PER_LAST);
    per_cnt_d = per_cnt_q + 1'b1;
    if (!en || tick) per_cnt_d = '0;
  end

  // Scan FSM: next state, datapath updates and the strt_cnv strobe.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    smp_cnt_d   = smp_cnt_q;
    acc_d       = acc_q;
    tmo_cnt_d   = tmo_cnt_q;
    cur_ch_d    = cur_ch_q;
    ch_vld_d    = 1'b0;
    ch_id_d     = ch_id_q;
    ch_avg_d    = ch_avg_q;
    scan_done_d = 1'b0;
    tmo_err_d   = tmo_err_q;
    strt_cnv    = 1'b0;

    // Only one early tick is remembered; later ones collapse onto it.
    if (tick && (state_q != IDLE)) pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (en && (tick || pend_q)) begin
          state_d = START;
          pend_d  = 1'b0;
        end
      end
      START: begin
        strt_cnv  = 1'b1;
        tmo_cnt_d = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        if (cnv_cmplt) begin
          if (!en) begin
            state_d   = IDLE;
            cur_ch_d  = '0;
            acc_d     = '0;
            smp_cnt_d = '0;
            pend_d    = 1'b0;
          end else if (smp_cnt_q == SMP_LAST) begin
            // Result registered on the way into PUB so ch_vld and
            // ch_avg appear together one cycle after the last sample.
            state_d     = PUB;
            ch_vld_d    = 1'b1;
            ch_id_d     = cur_ch_q;
            ch_avg_d    = avg_floor(acc_sum);
            scan_done_d = last_ch;
            acc_d       = '0;
            smp_cnt_d   = '0;
          end else begin
            acc_d     = acc_sum;
            smp_cnt_d = smp_cnt_q + 1'b1;
            state_d   = START;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          tmo_err_d = 1'b1;
          acc_d     = '0;
          smp_cnt_d = '0;
          if (!en) begin
            state_d  = IDLE;
            cur_ch_d = '0;
            pend_d   = 1'b0;
          end else if (last_ch) begin
            state_d     = IDLE;
            cur_ch_d    = '0;
            scan_done_d = 1'b1;
          end else begin
            state_d  = START;
            cur_ch_d = cur_ch_q + 3'd1;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      PUB: begin
        if (last_ch || !en) begin
          state_d  = IDLE;
          cur_ch_d = '0;
          if (!en) pend_d = 1'b0;
        end else begin
          state_d  = START;
          cur_ch_d = cur_ch_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything, including outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      per_cnt_q   <= '0;
      pend_q      <= 1'b0;
      smp_cnt_q   <= '0;
      acc_q       <= '0;
      tmo_cnt_q   <= '0;
      cur_ch_q    <= '0;
      ch_vld_q    <= 1'b0;
      ch_id_q     <= '0;
      ch_avg_q    <= '0;
      scan_done_q <= 1'b0;
      tmo_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      per_cnt_q   <= per_cnt_d;
      pend_q      <= pend_d;
      smp_cnt_q   <= smp_cnt_d;
      acc_q       <= acc_d;
      tmo_cnt_q   <= tmo_cnt_d;
      cur_ch_q    <= cur_ch_d;
      ch_vld_q    <= ch_vld_d;
      ch_id_q     <= ch_id_d;
      ch_avg_q    <= ch_avg_d;
      scan_done_q <= scan_done_d;
      tmo_err_q   <= tmo_err_d;
    end
  end

  assign chnnl     = cur_ch_q;
  assign ch_vld    = ch_vld_q;
  assign ch_id     = ch_id_q;
  assign ch_avg    = ch_avg_q;
  assign scan_done = scan_done_q;
  assign tmo_err   = tmo_err_q;

endmodule
